// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: machine word width and divider state encoding.
package cpu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, q} left by one and try to
// subtract the divisor from the widened partial remainder.
module div_step
   import cpu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // Trial subtract at WIDTH+1 bits; the top bit is the borrow that says the divisor did not fit.
   always_comb begin
      shifted = {rem_in, q_in[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      if (!trial[WIDTH]) begin
         rem_out = trial[WIDTH-1:0];
         q_out   = {q_in[WIDTH-2:0], 1'b1};
      end else begin
         rem_out = shifted[WIDTH-1:0];
         q_out   = {q_in[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned integer divider, one quotient bit per clock.
// Operands are reduced to magnitudes on accept, divided unsigned, and the
// signs are reapplied in the FIX state before the results are published.
module div_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   div_state_t     state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] dmag_q, dmag_d;
   logic           q_neg_q, q_neg_d;
   logic           r_neg_q, r_neg_d;
   logic           zero_q, zero_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic           done_q, done_d;
   logic           dbz_q, dbz_d;

   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .q_in    (work_q),
      .divisor (dmag_q),
      .rem_out (step_rem),
      .q_out   (step_q)
   );

   // Operand magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude.
   always_comb begin
      dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
   end

   // Next-state and datapath control; published results only move in FIX.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rem_d       = rem_q;
      work_d      = work_q;
      dmag_d      = dmag_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      zero_d      = zero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               q_neg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               r_neg_d = is_signed & dividend[WIDTH-1];
               count_d = '0;
               dmag_d  = divisor_mag;
               if (divisor == '0) begin
                  zero_d  = 1'b1;
                  rem_d   = dividend;
                  work_d  = '1;
                  state_d = FIX;
               end else begin
                  zero_d  = 1'b0;
                  rem_d   = '0;
                  work_d  = dividend_mag;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            rem_d   = step_rem;
            work_d  = step_q;
            count_d = count_q + 1'b1;
            if (count_q == LAST_COUNT) begin
               state_d = FIX;
            end
         end
         FIX: begin
            done_d  = 1'b1;
            dbz_d   = zero_q;
            state_d = IDLE;
            if (zero_q) begin
               quotient_d  = work_q;
               remainder_d = rem_q;
            end else begin
               quotient_d  = q_neg_q ? -work_q : work_q;
               remainder_d = r_neg_q ? -rem_q  : rem_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rem_q       <= '0;
         work_q      <= '0;
         dmag_q      <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         zero_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         work_q      <= work_d;
         dmag_q      <= dmag_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         zero_q      <= zero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a table of directed divisions plus
// hand-written sequences for ignored start, mid-run reset and back-to-back.
module tb_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int checks;
   int failures;
   int cyc;
   int acc_cyc;

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_q;
      logic [31:0] exp_r;
      logic        exp_dbz;
      int          exp_lat;
   } vec_t;

   vec_t vecs[12];

   div_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Free-running clock and an edge counter used to measure latency.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Present operands with start for one edge; return #1 after the accept edge.
   task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'b0;
      check_output("busy_after_accept", {31'b0, busy}, 32'd1);
   endtask

   // Wait for done with a cycle budget; busy must stay high until then.
   task automatic wait_done(output int lat);
      bit busy_ok;
      busy_ok = 1'b1;
      while (done !== 1'b1 && (cyc - acc_cyc) < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         #1;
      end
      lat = cyc - acc_cyc;
      check_output("done_seen", {31'b0, done}, 32'd1);
      check_output("busy_held_until_done", {31'b0, busy_ok}, 32'd1);
      check_output("busy_low_at_done", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int lat;
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      acc_cyc   = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;

      vecs[0]  = '{"u_100_7",        1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
      vecs[1]  = '{"s_m7_2",         1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
      vecs[2]  = '{"s_7_m2",         1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33};
      vecs[3]  = '{"u_5_0",          1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
      vecs[4]  = '{"s_5_0",          1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
      vecs[5]  = '{"s_min_m1",       1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33};
      vecs[6]  = '{"u_min_max",      1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33};
      vecs[7]  = '{"u_max_1",        1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33};
      vecs[8]  = '{"s_m100_m7",      1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33};
      vecs[9]  = '{"u_0_5",          1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
      vecs[10] = '{"s_m5_0",         1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1};
      vecs[11] = '{"u_deadbeef_16",  1'b0, 32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'h0000000F,   1'b0, 33};

      #12;
      check_output("reset_busy", {31'b0, busy}, 32'd0);
      check_output("reset_done", {31'b0, done}, 32'd0);
      check_output("reset_quotient", quotient, 32'd0);
      check_output("reset_remainder", remainder, 32'd0);
      check_output("reset_dbz", {31'b0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         apply_stimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
         wait_done(lat);
         check_output({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
         check_output({vecs[i].name, "_quotient"}, quotient, vecs[i].exp_q);
         check_output({vecs[i].name, "_remainder"}, remainder, vecs[i].exp_r);
         check_output({vecs[i].name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, vecs[i].exp_dbz});
         @(posedge clk);
         #1;
         check_output({vecs[i].name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
         check_output({vecs[i].name, "_quotient_held"}, quotient, vecs[i].exp_q);
      end

      // A start pulse in the middle of a run must be ignored.
      apply_stimulus(1'b0, 32'd100, 32'd7);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      is_signed = 1'b1;
      dividend  = 32'd50;
      divisor   = 32'd0;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      wait_done(lat);
      check_output("ignored_start_latency", lat, 33);
      check_output("ignored_start_quotient", quotient, 32'd14);
      check_output("ignored_start_remainder", remainder, 32'd2);
      check_output("ignored_start_dbz", {31'b0, div_by_zero}, 32'd0);

      // Asynchronous reset mid-run clears everything immediately.
      @(posedge clk);
      #1;
      apply_stimulus(1'b0, 32'd1000, 32'd3);
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrun_reset_busy", {31'b0, busy}, 32'd0);
      check_output("midrun_reset_done", {31'b0, done}, 32'd0);
      check_output("midrun_reset_quotient", quotient, 32'd0);
      check_output("midrun_reset_remainder", remainder, 32'd0);
      check_output("midrun_reset_dbz", {31'b0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("after_reset_idle", {31'b0, busy}, 32'd0);

      // Back-to-back: start held during the done cycle is accepted.
      apply_stimulus(1'b0, 32'd5, 32'd3);
      wait_done(lat);
      check_output("b2b_first_latency", lat, 33);
      check_output("b2b_first_quotient", quotient, 32'd1);
      check_output("b2b_first_remainder", remainder, 32'd2);
      apply_stimulus(1'b0, 32'hFFFFFFFF, 32'd1);
      check_output("b2b_done_dropped", {31'b0, done}, 32'd0);
      check_output("b2b_first_result_held", quotient, 32'd1);
      wait_done(lat);
      check_output("b2b_second_latency", lat, 33);
      check_output("b2b_second_quotient", quotient, 32'hFFFFFFFF);
      check_output("b2b_second_remainder", remainder, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
